// File: rtl/serial_adder_seq_pkg.sv
// Shared types for the bit-serial adder sequencer: FSM state encoding and
// the bit-counter width helper.
package serial_adder_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Counter must index WIDTH bits; keep at least one bit for tiny widths.
   function automatic int cnt_width(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

endpackage

// File: rtl/serial_adder_seq_fa_bit.sv
// fa_bit: gate-level 1-bit full adder used as the single arithmetic cell of
// the serial adder datapath.
module fa_bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   logic a_xor_b;

   assign a_xor_b = a ^ b;
   assign sum     = a_xor_b ^ cin;
   assign cout    = (a & b) | (a_xor_b & cin);

endmodule

// File: rtl/serial_adder_seq.sv
// serial_adder_seq: WIDTH-bit adder that streams operands LSB-first through one
// fa_bit cell. Define SERIAL_ADD_OVF_EN to add the registered signed-overflow output ovf.
module serial_adder_seq
   import serial_adder_seq_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef SERIAL_ADD_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sh_a_q;
   logic [WIDTH-1:0] sh_b_q;
   logic [WIDTH-2:0] sh_s_q;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
`ifdef SERIAL_ADD_OVF_EN
   logic             ovf_q;
`endif

   logic             fa_s;
   logic             fa_c;
   logic [WIDTH-1:0] sh_s_d;

   fa_bit u_fa (
      .a    (sh_a_q[0]),
      .b    (sh_b_q[0]),
      .cin  (carry_q),
      .sum  (fa_s),
      .cout (fa_c)
   );

   // sh_s_q keeps only the upper bits collected so far; the new bit enters at the MSB.
   assign sh_s_d = {fa_s, sh_s_q};

   // NOTE: every register here is written with <= so each branch reads pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         sh_s_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
         ovf_q   <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  sh_a_q  <= a;
                  sh_b_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               carry_q <= fa_c;
               sh_a_q  <= sh_a_q >> 1;
               sh_b_q  <= sh_b_q >> 1;
               sh_s_q  <= sh_s_d[WIDTH-1:1];
               if (cnt_q == CNT_LAST) begin
                  sum_q   <= sh_s_d;
                  cout_q  <= fa_c;
`ifdef SERIAL_ADD_OVF_EN
                  // carry_q here is the carry into the MSB.
                  ovf_q   <= carry_q ^ fa_c;
`endif
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
   assign ovf  = ovf_q;
`endif

endmodule
